// File: rtl/mul_8x8_pkg.sv
// Shared widths and types for the pipelined unsigned 8x8 multiplier.
// LATENCY is exported so instantiating datapaths can delay-match parallel paths.
package mul_8x8_pkg;

  localparam int unsigned A_W     = 8;
  localparam int unsigned B_W     = 8;
  localparam int unsigned P_W     = 16;
  localparam int unsigned LATENCY = 3;

  // Internal adder-tree widths: two 8-bit partial products (one shifted by 1)
  // fit in 10 bits; two rows (one shifted by 2) fit in 12 bits.
  localparam int unsigned ROWS  = 4;
  localparam int unsigned ROW_W = 10;
  localparam int unsigned SUM_W = 12;

  typedef logic [A_W-1:0] operand_t;
  typedef logic [P_W-1:0] product_t;
  typedef logic [ROW_W-1:0] row_t;
  typedef logic [SUM_W-1:0] sum_t;

  // Row k carries weight 4**k in the final product.
  typedef logic [ROWS-1:0][ROW_W-1:0] rows_t;

endpackage

// File: rtl/mul_8x8_pp_gen.sv
// Partial-product generator plus first adder level for mul_8x8.
// Purely combinational.
// Ports:
//   a      - multiplicand, unsigned
//   b      - multiplier, unsigned (may be a constant tie-off)
//   rows_c - 4 row sums; row k = pp[2k] + (pp[2k+1] << 1), weight 4**k
module mul_8x8_pp_gen
  import mul_8x8_pkg::*;
(
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output rows_t          rows_c
);

  // Each partial product is a gated by one bit of b; pairs are summed here.
  always_comb begin
    rows_c = '0;
    for (int k = 0; k < ROWS; k++) begin
      rows_c[k] = ROW_W'(a & {A_W{b[2*k]}})
                + (ROW_W'(a & {A_W{b[2*k+1]}}) << 1);
    end
  end

endmodule

// File: rtl/mul_8x8.sv
// Fully pipelined unsigned 8x8 -> 16-bit multiplier, fixed latency of three
// register stages, one product per cycle.
// Optional feature: define MUL_8X8_CE_EN to add a clock-enable port.
// Ports:
//   clk  - rising-edge clock
//   rstn - asynchronous active-low reset; clears every stage and p
//   ce   - clock enable, present only with MUL_8X8_CE_EN
//   a    - multiplicand, unsigned
//   b    - multiplier, unsigned
//   p    - registered product a*b
module mul_8x8
  import mul_8x8_pkg::*;
(
  input  logic           clk,
  input  logic           rstn,
`ifdef MUL_8X8_CE_EN
  input  logic           ce,
`endif
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output product_t       p
);

  rows_t    rows_c;
  rows_t    rows_q;
  sum_t     s0_c;
  sum_t     s1_c;
  sum_t     s0_q;
  sum_t     s1_q;
  product_t p_c;
  logic     adv_c;

  // Pipeline advance qualifier.
`ifdef MUL_8X8_CE_EN
  assign adv_c = ce;
`else
  assign adv_c = 1'b1;
`endif

  // Stage-1 combinational: partial products and first adder level.
  mul_8x8_pp_gen u_pp_gen (
    .a      (a),
    .b      (b),
    .rows_c (rows_c)
  );

  // Stage-2 combinational: pair rows (weights 1/4 and 16/64).
  assign s0_c = SUM_W'(rows_q[0]) + (SUM_W'(rows_q[1]) << 2);
  assign s1_c = SUM_W'(rows_q[2]) + (SUM_W'(rows_q[3]) << 2);

  // Stage-3 combinational: final add; max 65025 so no carry out of 16 bits.
  assign p_c = P_W'(s0_q) + (P_W'(s1_q) << 4);

  // Three register stages; reset overrides the enable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rows_q <= '0;
      s0_q   <= '0;
      s1_q   <= '0;
      p      <= '0;
    end else if (adv_c) begin
      rows_q <= rows_c;
      s0_q   <= s0_c;
      s1_q   <= s1_c;
      p      <= p_c;
    end
  end

endmodule

// File: tb/tb_mul_8x8.sv
// Self-checking bench for mul_8x8: scoreboard queue of golden products,
// pushed when an input is sampled and popped LATENCY-1 edges later.
module tb_mul_8x8;
  import mul_8x8_pkg::*;

  logic     clk  = 1'b0;
  logic     rstn = 1'b0;
  logic     ce_tb;
  operand_t a;
  operand_t b;
  product_t p;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  product_t exp_q[$];
  product_t last_exp;

  always #5 clk = ~clk;

  mul_8x8 dut (
    .clk  (clk),
    .rstn (rstn),
`ifdef MUL_8X8_CE_EN
    .ce   (ce_tb),
`endif
    .a    (a),
    .b    (b),
    .p    (p)
  );

  task automatic check_eq(input string tag, input product_t got, input product_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: p=%0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pipeline after reset holds zeros in the stages ahead of p.
  task automatic restart_pipe();
    exp_q.delete();
    for (int i = 0; i < int'(LATENCY) - 1; i++) exp_q.push_back(16'h0000);
    last_exp = 16'h0000;
  endtask

  // Drive one input set, clock once, compare p #1 after the edge.
  task automatic step(input string tag, input operand_t va, input operand_t vb,
                      input logic vce);
    a     = va;
    b     = vb;
    ce_tb = vce;
    @(posedge clk);
    if (vce) begin
      exp_q.push_back(16'(va) * 16'(vb));
      if (exp_q.size() > int'(LATENCY) - 1) last_exp = exp_q.pop_front();
    end
    #1;
    check_eq(tag, p, last_exp);
  endtask

  operand_t ca [5] = '{8'd0, 8'd255, 8'd255, 8'd1,   8'd128};
  operand_t cb [5] = '{8'd0, 8'd255, 8'd1,   8'd255, 8'd128};

  initial begin
    a        = 8'hFF;
    b        = 8'hFF;
    ce_tb    = 1'b1;
    last_exp = 16'h0000;

    // Reset held with max operands and a running clock.
    repeat (4) begin
      @(posedge clk);
      #1;
      check_eq("reset_hold", p, 16'h0000);
    end
    @(negedge clk);
    rstn = 1'b1;
    restart_pipe();

    // Latency: 15400 only on the third sampled edge.
    step("latency", 8'd77, 8'd200, 1'b1);
    repeat (5) step("latency_tail", 8'd0, 8'd0, 1'b1);

    // Corners back-to-back.
    for (int i = 0; i < 5; i++) step("corner", ca[i], cb[i], 1'b1);
    repeat (3) step("corner_flush", 8'd0, 8'd0, 1'b1);

    // Constant coefficient sweep.
    for (int i = 0; i < 256; i++) step("coef150", 8'(i), 8'd150, 1'b1);

    // Random stream.
    for (int i = 0; i < 10000; i++)
      step("random", 8'($urandom), 8'($urandom), 1'b1);

    // Mid-stream asynchronous reset: p must clear before the next edge.
    repeat (3) step("pre_reset", 8'd255, 8'd255, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    check_eq("async_reset", p, 16'h0000);
    @(negedge clk);
    rstn = 1'b1;
    restart_pipe();
    // In-flight 65025 products must not reappear.
    step("post_reset", 8'd3, 8'd5, 1'b1);
    repeat (3) step("post_reset", 8'd0, 8'd0, 1'b1);

`ifdef MUL_8X8_CE_EN
    // Random enable pattern: p advances on ce=1 edges, holds otherwise.
    for (int i = 0; i < 400; i++)
      step("ce_random", 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_8x8.md
# mul_8x8

Fully pipelined unsigned 8×8 → 16-bit multiplier with a fixed latency of three clock edges and a throughput of one product per cycle. It is the shared arithmetic primitive used by pixel-processing datapaths such as colour-space conversion. Those callers depend on the latency being constant so they can pad parallel paths by cycle count alone.

## Interface
- Parameters: none. Widths are fixed at 8×8 → 16.
- clk  input  1  rising-edge clock.
- rstn  input  1  reset: asynchronous, active-low.
- ce  input  1  clock enable. Present only with MUL_8X8_CE_EN.
- a  input  8  multiplicand, unsigned.
- b  input  8  multiplier, unsigned. May be a constant tie-off.
- p  output  16  product a×b, unsigned, registered.

## Operation
- p = a × b, computed exactly with no truncation. The full range is 0..65025, so 16 bits never overflow.
- Pipeline stage 1 (edge t):
  - Form 8 partial products, a AND'ed with b[i], shifted by i.
  - Sum them pairwise into 4 row sums of 10 bits each (plus shift).
  - Register the 4 row sums.
- Pipeline stage 2 (edge t+1): add the row sums pairwise into 2 sums of 12 bits (plus shift), and register them.
- Pipeline stage 3 (edge t+2): add the final pair, then register the 16-bit result into p.
- The block is stateless apart from the pipeline. There is no handshake: every cycle's inputs produce exactly one output three edges later.
- Constant b is permitted. Synthesis may prune the unused partial products; behaviour is identical either way.

## Timing
- Inputs are sampled at rising edge t. p shows a×b after edge t+2 and holds it until edge t+3.
- Latency is 3 register stages. Throughput is 1 per cycle, with no bubbles and no stalls unless MUL_8X8_CE_EN is defined.
- Back-to-back input changes each cycle yield the corresponding back-to-back outputs in order.
- Reset:
  - rstn low asynchronously clears all pipeline registers and p to 16'h0000.
  - Clearing is immediate, with no clock required.
- Reset mid-operation: in-flight products are discarded.
- First edge after rstn rises:
  - Inputs are sampled normally.
  - p stays 0 for the next two edges (cleared pipeline contents), then shows the first valid product.
- Combinational a/b glitches between edges have no effect on p.

## Configuration
- MUL_8X8_CE_EN defined:
  - Port ce is added.
  - When ce=0, all three stages and p hold their values.
  - When ce=1, the pipeline advances one stage.
  - Latency is counted in ce=1 edges.
  - Reset overrides ce.
- MUL_8X8_CE_EN undefined:
  - No ce port exists.
  - The pipeline advances on every clk edge.

## Structure
- Package mul_8x8_pkg holds:
  - A_W=8, B_W=8, P_W=16, LATENCY=3.
  - Typedefs operand_t (logic [7:0]) and product_t (logic [15:0]).
- Instantiating datapaths use LATENCY from the package for delay matching.
- One sub-module, mul_8x8_pp_gen: a combinational partial-product generator plus first-level adder. It takes a and b and produces the 4 row sums.
- The top level mul_8x8 holds the three register stages and the stage-2/3 adders.

## Test plan
- Reset: hold rstn=0 with a=8'hFF, b=8'hFF, toggling clk → p=0 throughout. Assert rstn low mid-stream → p goes to 0 immediately, without waiting for an edge.
- Latency:
  - Stimulus: a=77, b=200 at edge t, then a=0, b=0.
  - Required: p=15400 after edge t+2, and p=0 after edge t+3.
  - p must never show 15400 at any other edge.
- Corners, streamed one per cycle:
  - 0×0 → 0
  - 255×255 → 65025
  - 255×1 → 255
  - 1×255 → 255
  - 128×128 → 16384
  - Required: results appear in order, with 3-edge latency and no gaps.
- Constant coefficient:
  - Stimulus: b tied to 150, with a swept 0..255 one value per cycle.
  - Required: p = a×150 for each value, three edges after it is applied.
- Randomized: 10,000 random a,b pairs per cycle → p matches the a×b golden model delayed by 3 edges.
- With MUL_8X8_CE_EN: stream values with ce toggling in a random pattern → p follows the golden model delayed by 3 ce-qualified edges, and p holds while ce=0.
